// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared constants, level encoding, FSM state type and vector helpers for the
// interrupt dispatch stage behind the 27-channel (3 levels x 9 channels)
// interrupt priority controller.
// No ports (package).
// -----------------------------------------------------------------------------
package irq_pkg;

  localparam int unsigned NUM_CH  = 32'd9;
  localparam int unsigned NUM_LVL = 32'd3;
  localparam int unsigned NUM_VEC = 32'd27;
  localparam int unsigned VEC_W   = 32'd5;

  localparam logic [1:0] LVL_A = 2'd0;
  localparam logic [1:0] LVL_B = 2'd1;
  localparam logic [1:0] LVL_C = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    PRESENT = 2'd2,
    SERVICE = 2'd3
  } state_t;

  // Vector number = level*9 + chan, with level*9 formed as (level<<3)+level.
  function automatic logic [VEC_W-1:0] vec_of(input logic [1:0] lvl,
                                              input logic [3:0] ch);
    logic [VEC_W-1:0] l5;
    l5 = {3'b000, lvl};
    return (l5 << 3'd3) + l5 + {1'b0, ch};
  endfunction

  // One-hot mask with only the bit of the given vector set.
  function automatic logic [NUM_VEC-1:0] vec_onehot(input logic [VEC_W-1:0] v);
    return {{(NUM_VEC-1){1'b0}}, 1'b1} << v;
  endfunction

endpackage

// File: rtl/irq_dispatch_if.sv
// -----------------------------------------------------------------------------
// irq_dispatch_if
// CPU-side interrupt handshake bundle.
//   irq_valid   dispatch -> CPU  vector presented
//   irq_ready   CPU -> dispatch  vector accepted
//   irq_vector  dispatch -> CPU  level*9 + chan (0..26)
//   irq_level   dispatch -> CPU  0=A, 1=B, 2=C
//   eoi         CPU -> dispatch  end-of-interrupt pulse
//   busy        dispatch -> CPU  a vector is in service
//   timeout_err dispatch -> CPU  one-cycle watchdog expiry pulse
// Modports: master = dispatch side, slave = CPU side.
// -----------------------------------------------------------------------------
interface irq_dispatch_if;
  import irq_pkg::*;

  logic             irq_valid;
  logic             irq_ready;
  logic [VEC_W-1:0] irq_vector;
  logic [1:0]       irq_level;
  logic             eoi;
  logic             busy;
  logic             timeout_err;

  modport master (
    output irq_valid, irq_vector, irq_level, busy, timeout_err,
    input  irq_ready, eoi
  );

  modport slave (
    input  irq_valid, irq_vector, irq_level, busy, timeout_err,
    output irq_ready, eoi
  );

endinterface

// File: rtl/irq_qualifier.sv
// -----------------------------------------------------------------------------
// irq_qualifier
// Candidate (level, chan) register plus stability counter.
//   clk, rst             clock, synchronous active-high reset
//   en                   sampling active (IDLE or QUALIFY)
//   restart              force a fresh capture this cycle (IDLE)
//   req, req_level,
//   req_chan             decoded request from the controller outputs
//   cand_level,
//   cand_chan            candidate as it will be held after this edge
//   stable               this edge completes STABLE_CYC matching samples
// -----------------------------------------------------------------------------
module irq_qualifier
  import irq_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       restart,
  input  logic       req,
  input  logic [1:0] req_level,
  input  logic [3:0] req_chan,
  output logic [1:0] cand_level,
  output logic [3:0] cand_chan,
  output logic       stable
);

  logic [1:0] lvl_r;
  logic [3:0] chan_r;
  logic [3:0] cnt_r;
  logic       match_s;
  logic       capture_s;
  logic [4:0] cnt_inc_s;

  // Match/capture decode and the "stable after this edge" flag.
  always_comb begin
    match_s   = (req_level == lvl_r) && (req_chan == chan_r);
    cnt_inc_s = {1'b0, cnt_r} + 5'd1;
    capture_s = en && req && (restart || !match_s);
    stable    = 1'b0;
    if (!(en && req)) begin
      stable = 1'b0;
    end else if (capture_s) begin
      stable = (STABLE_CYC == 32'd1);
    end else begin
      stable = (32'(cnt_inc_s) >= STABLE_CYC);
    end
    if (capture_s) begin
      cand_level = req_level;
      cand_chan  = req_chan;
    end else begin
      cand_level = lvl_r;
      cand_chan  = chan_r;
    end
  end

  // Candidate register and saturating stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_r  <= LVL_A;
      chan_r <= 4'd0;
      cnt_r  <= 4'd0;
    end else if (capture_s) begin
      lvl_r  <= req_level;
      chan_r <= req_chan;
      cnt_r  <= 4'd1;
    end else if (en && req) begin
      if (cnt_r != 4'hF) begin
        cnt_r <= cnt_r + 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end else if (en) begin
      cnt_r <= 4'd0;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/irq_dispatch.sv
// -----------------------------------------------------------------------------
// irq_dispatch
// Qualifies a stable winning request from the priority controller, presents it
// to the CPU as a 5-bit vector over valid/ready, then holds it in service until
// end-of-interrupt while masking the serviced vector back at the controller.
//   clk, rst       clock, synchronous active-high reset
//   pa, pb, pc     level A/B/C request present (A highest)
//   chan           winning channel within the winning level (0..8)
//   emask          per-vector mask, 1 = masked (only the vector in service)
//   cpu            irq_dispatch_if.master handshake bundle
// Optional build macro IRQ_TIMEOUT_EN: adds a service watchdog of TIMEOUT_CYC
// cycles that forces a return to IDLE and pulses timeout_err. Without it,
// timeout_err is tied low and SERVICE waits for eoi indefinitely.
// -----------------------------------------------------------------------------
module irq_dispatch
  import irq_pkg::*;
#(
  parameter int unsigned STABLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pa,
  input  logic               pb,
  input  logic               pc,
  input  logic [3:0]         chan,
  output logic [NUM_VEC-1:0] emask,
  irq_dispatch_if.master     cpu
);

  state_t             state_r;
  logic               irq_valid_r;
  logic [VEC_W-1:0]   irq_vector_r;
  logic [1:0]         irq_level_r;
  logic               busy_r;
  logic [NUM_VEC-1:0] emask_r;

  logic               req_s;
  logic [1:0]         req_level_s;
  logic [1:0]         cand_level_s;
  logic [3:0]         cand_chan_s;
  logic [VEC_W-1:0]   cand_vec_s;
  logic               stable_s;
  logic               qual_en_s;
  logic               qual_restart_s;

`ifdef IRQ_TIMEOUT_EN
  localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  logic [WD_W-1:0] wd_r;
  logic            timeout_err_r;
`endif

  // Level select: A over B over C; an out-of-range channel means no request.
  always_comb begin
    req_s       = 1'b0;
    req_level_s = LVL_A;
    if (32'(chan) >= NUM_CH) begin
      req_s       = 1'b0;
      req_level_s = LVL_A;
    end else if (pa) begin
      req_s       = 1'b1;
      req_level_s = LVL_A;
    end else if (pb) begin
      req_s       = 1'b1;
      req_level_s = LVL_B;
    end else if (pc) begin
      req_s       = 1'b1;
      req_level_s = LVL_C;
    end else begin
      req_s       = 1'b0;
      req_level_s = LVL_A;
    end
  end

  // The qualifier only samples while waiting; IDLE always starts a fresh run.
  assign qual_en_s      = (state_r == IDLE) || (state_r == QUALIFY);
  assign qual_restart_s = (state_r == IDLE);
  assign cand_vec_s     = vec_of(cand_level_s, cand_chan_s);

  irq_qualifier #(
    .STABLE_CYC (STABLE_CYC)
  ) u_qual (
    .clk        (clk),
    .rst        (rst),
    .en         (qual_en_s),
    .restart    (qual_restart_s),
    .req        (req_s),
    .req_level  (req_level_s),
    .req_chan   (chan),
    .cand_level (cand_level_s),
    .cand_chan  (cand_chan_s),
    .stable     (stable_s)
  );

  // Dispatch FSM with registered handshake, busy and mask outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      irq_valid_r   <= 1'b0;
      irq_vector_r  <= {VEC_W{1'b0}};
      irq_level_r   <= 2'd0;
      busy_r        <= 1'b0;
      emask_r       <= {NUM_VEC{1'b0}};
`ifdef IRQ_TIMEOUT_EN
      wd_r          <= {WD_W{1'b0}};
      timeout_err_r <= 1'b0;
`endif
    end else begin
`ifdef IRQ_TIMEOUT_EN
      timeout_err_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (req_s && stable_s) begin
            state_r      <= PRESENT;
            irq_valid_r  <= 1'b1;
            irq_vector_r <= cand_vec_s;
            irq_level_r  <= cand_level_s;
          end else if (req_s) begin
            state_r <= QUALIFY;
          end else begin
            state_r <= IDLE;
          end
        end
        QUALIFY: begin
          if (!req_s) begin
            state_r <= IDLE;
          end else if (stable_s) begin
            state_r      <= PRESENT;
            irq_valid_r  <= 1'b1;
            irq_vector_r <= cand_vec_s;
            irq_level_r  <= cand_level_s;
          end else begin
            state_r <= QUALIFY;
          end
        end
        PRESENT: begin
          // Vector and level stay frozen here regardless of the inputs.
          if (cpu.irq_ready) begin
            state_r     <= SERVICE;
            irq_valid_r <= 1'b0;
            busy_r      <= 1'b1;
            emask_r     <= vec_onehot(irq_vector_r);
`ifdef IRQ_TIMEOUT_EN
            wd_r        <= {WD_W{1'b0}};
`endif
          end else begin
            state_r <= PRESENT;
          end
        end
        SERVICE: begin
          // eoi wins over a watchdog expiry in the same cycle.
          if (cpu.eoi) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            emask_r <= {NUM_VEC{1'b0}};
          end
`ifdef IRQ_TIMEOUT_EN
          else if (wd_r == WD_LAST) begin
            state_r       <= IDLE;
            busy_r        <= 1'b0;
            emask_r       <= {NUM_VEC{1'b0}};
            timeout_err_r <= 1'b1;
          end else begin
            wd_r <= wd_r + WD_ONE;
          end
`else
          else begin
            state_r <= SERVICE;
          end
`endif
        end
        default: begin
          state_r     <= IDLE;
          irq_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          emask_r     <= {NUM_VEC{1'b0}};
        end
      endcase
    end
  end

  assign cpu.irq_valid  = irq_valid_r;
  assign cpu.irq_vector = irq_vector_r;
  assign cpu.irq_level  = irq_level_r;
  assign cpu.busy       = busy_r;
  assign emask          = emask_r;
`ifdef IRQ_TIMEOUT_EN
  assign cpu.timeout_err = timeout_err_r;
`else
  assign cpu.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_irq_dispatch.sv
// -----------------------------------------------------------------------------
// tb_irq_dispatch
// Self-checking bench for irq_dispatch: directed scenario tasks with inline
// checks plus a cycle-level reference model compared every cycle on negedge.
// -----------------------------------------------------------------------------
module tb_irq_dispatch;

  localparam int STABLE = 2;
  localparam int TO     = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pa, pb, pc;
  logic [3:0]  chan;
  logic [26:0] emask;

  irq_dispatch_if cpu_if ();

  irq_dispatch #(
    .STABLE_CYC  (STABLE),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pa    (pa),
    .pb    (pb),
    .pc    (pc),
    .chan  (chan),
    .emask (emask),
    .cpu   (cpu_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: waiting / presenting / servicing, run length of the
  // same requested vector, and the expected outputs.
  int          m_phase = 0;
  int          m_prev  = -1;
  int          m_run   = 0;
  int          m_svc   = 0;
  int          m_vec   = 0;
  int          m_lvl   = 0;
  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_terr  = 1'b0;
  logic [26:0] m_mask  = 27'd0;
  bit          sb_en   = 1'b0;

  // Model update from the inputs sampled at each rising edge.
  always @(posedge clk) begin : model
    int r;
    if (rst) begin
      m_phase = 0; m_prev = -1; m_run = 0; m_svc = 0; m_vec = 0; m_lvl = 0;
      m_valid = 1'b0; m_busy = 1'b0; m_terr = 1'b0; m_mask = 27'd0;
    end else begin
      m_terr = 1'b0;
      if (m_phase == 0) begin
        r = -1;
        if (chan <= 4'd8) begin
          if (pa)      r = int'(chan);
          else if (pb) r = 9 + int'(chan);
          else if (pc) r = 18 + int'(chan);
        end
        if (r < 0) begin
          m_run = 0; m_prev = -1;
        end else if (r == m_prev) begin
          m_run++;
        end else begin
          m_run = 1; m_prev = r;
        end
        if (m_run >= STABLE) begin
          m_phase = 1; m_valid = 1'b1; m_vec = r; m_lvl = r / 9;
        end
      end else if (m_phase == 1) begin
        if (cpu_if.irq_ready) begin
          m_phase = 2; m_valid = 1'b0; m_busy = 1'b1;
          m_mask = 27'd1 << m_vec; m_svc = 0;
        end
      end else begin
        m_svc++;
        if (cpu_if.eoi) begin
          m_phase = 0; m_busy = 1'b0; m_mask = 27'd0; m_prev = -1; m_run = 0;
        end
`ifdef IRQ_TIMEOUT_EN
        else if (m_svc == TO) begin
          m_phase = 0; m_busy = 1'b0; m_mask = 27'd0; m_prev = -1; m_run = 0;
          m_terr = 1'b1;
        end
`endif
      end
    end
  end

  // Scoreboard: compare DUT outputs against the model away from the edge.
  always @(negedge clk) begin
    if (sb_en) begin
      checks++;
      if (cpu_if.irq_valid !== m_valid) begin
        errors++;
        $display("FAIL sb_valid t=%0t got=%0b exp=%0b", $time, cpu_if.irq_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (cpu_if.irq_vector !== 5'(m_vec) || cpu_if.irq_level !== 2'(m_lvl)) begin
          errors++;
          $display("FAIL sb_vector t=%0t got=%0d/%0d exp=%0d/%0d", $time,
                   cpu_if.irq_vector, cpu_if.irq_level, m_vec, m_lvl);
        end
      end
      checks++;
      if (cpu_if.busy !== m_busy) begin
        errors++;
        $display("FAIL sb_busy t=%0t got=%0b exp=%0b", $time, cpu_if.busy, m_busy);
      end
      checks++;
      if (emask !== m_mask) begin
        errors++;
        $display("FAIL sb_emask t=%0t got=%h exp=%h", $time, emask, m_mask);
      end
      checks++;
      if (cpu_if.timeout_err !== m_terr) begin
        errors++;
        $display("FAIL sb_timeout_err t=%0t got=%0b exp=%0b", $time, cpu_if.timeout_err, m_terr);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    pa = 1'b0; pb = 1'b0; pc = 1'b0; chan = 4'd0;
    cpu_if.irq_ready = 1'b0; cpu_if.eoi = 1'b0;
  endtask

  // Accept the presented vector, drop the request, then end the service.
  task automatic finish_service();
    cpu_if.irq_ready = 1'b1;
    cyc(1);
    clear_inputs();
    cpu_if.eoi = 1'b1;
    cyc(1);
    cpu_if.eoi = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    cyc(2);
    checks++;
    if (cpu_if.irq_valid !== 1'b0 || cpu_if.irq_vector !== 5'd0 || cpu_if.irq_level !== 2'd0) begin
      errors++;
      $display("FAIL reset_handshake got v=%0b vec=%0d lvl=%0d exp 0/0/0",
               cpu_if.irq_valid, cpu_if.irq_vector, cpu_if.irq_level);
    end
    checks++;
    if (cpu_if.busy !== 1'b0 || emask !== 27'd0 || cpu_if.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_service got busy=%0b emask=%h terr=%0b exp 0/0/0",
               cpu_if.busy, emask, cpu_if.timeout_err);
    end
    rst = 1'b0;
    sb_en = 1'b1;
    cyc(1);
  endtask

  task automatic test_basic();
    pb = 1'b1; chan = 4'd5;
    cyc(1);
    checks++;
    if (cpu_if.irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early got=%0b exp=0", cpu_if.irq_valid);
    end
    cyc(1);
    checks++;
    if (cpu_if.irq_valid !== 1'b1 || cpu_if.irq_vector !== 5'd14 || cpu_if.irq_level !== 2'd1) begin
      errors++;
      $display("FAIL basic_present got v=%0b vec=%0d lvl=%0d exp 1/14/1",
               cpu_if.irq_valid, cpu_if.irq_vector, cpu_if.irq_level);
    end
    cyc(1);
    cpu_if.irq_ready = 1'b1;
    cyc(1);
    cpu_if.irq_ready = 1'b0;
    pb = 1'b0;
    checks++;
    if (cpu_if.busy !== 1'b1 || emask !== 27'h0004000 || cpu_if.irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_service got busy=%0b emask=%h v=%0b exp 1/0004000/0",
               cpu_if.busy, emask, cpu_if.irq_valid);
    end
    cpu_if.eoi = 1'b1;
    cyc(1);
    cpu_if.eoi = 1'b0;
    checks++;
    if (cpu_if.busy !== 1'b0 || emask !== 27'd0) begin
      errors++;
      $display("FAIL basic_eoi got busy=%0b emask=%h exp 0/0", cpu_if.busy, emask);
    end
    cyc(1);
  endtask

  task automatic test_toggle();
    pa = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chan = (i % 2 == 0) ? 4'd3 : 4'd4;
      cyc(1);
      checks++;
      if (cpu_if.irq_valid !== 1'b0) begin
        errors++;
        $display("FAIL toggle_quiet step=%0d got=%0b exp=0", i, cpu_if.irq_valid);
      end
    end
    chan = 4'd7;
    cyc(1);
    checks++;
    if (cpu_if.irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL toggle_settle got=%0b exp=0", cpu_if.irq_valid);
    end
    cyc(1);
    checks++;
    if (cpu_if.irq_valid !== 1'b1 || cpu_if.irq_vector !== 5'd7) begin
      errors++;
      $display("FAIL toggle_present got v=%0b vec=%0d exp 1/7", cpu_if.irq_valid, cpu_if.irq_vector);
    end
    finish_service();
  endtask

  task automatic test_sticky();
    pc = 1'b1; chan = 4'd2;
    cyc(2);
    checks++;
    if (cpu_if.irq_valid !== 1'b1 || cpu_if.irq_vector !== 5'd20 || cpu_if.irq_level !== 2'd2) begin
      errors++;
      $display("FAIL sticky_present got v=%0b vec=%0d lvl=%0d exp 1/20/2",
               cpu_if.irq_valid, cpu_if.irq_vector, cpu_if.irq_level);
    end
    clear_inputs();
    for (int i = 0; i < 10; i++) begin
      chan = 4'($urandom_range(0, 9));
      cpu_if.eoi = 1'($urandom_range(0, 1));
      cyc(1);
      checks++;
      if (cpu_if.irq_valid !== 1'b1 || cpu_if.irq_vector !== 5'd20) begin
        errors++;
        $display("FAIL sticky_hold cycle=%0d got v=%0b vec=%0d exp 1/20",
                 i, cpu_if.irq_valid, cpu_if.irq_vector);
      end
    end
    finish_service();
  endtask

  task automatic test_chan9();
    pa = 1'b1; pb = 1'b1; chan = 4'd9;
    for (int i = 0; i < 5; i++) begin
      cpu_if.irq_ready = 1'b1;
      cyc(1);
      checks++;
      if (cpu_if.irq_valid !== 1'b0 || cpu_if.busy !== 1'b0) begin
        errors++;
        $display("FAIL chan9_ignored cycle=%0d got v=%0b busy=%0b exp 0/0",
                 i, cpu_if.irq_valid, cpu_if.busy);
      end
    end
    clear_inputs();
    cyc(1);
  endtask

  task automatic test_rst_service();
    pc = 1'b1; chan = 4'd8;
    cyc(2);
    cpu_if.irq_ready = 1'b1;
    cyc(1);
    clear_inputs();
    checks++;
    if (emask !== 27'h4000000 || cpu_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_svc_entry got emask=%h busy=%0b exp 4000000/1", emask, cpu_if.busy);
    end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    checks++;
    if (emask !== 27'd0 || cpu_if.busy !== 1'b0 || cpu_if.irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_svc_clear got emask=%h busy=%0b v=%0b exp 0/0/0",
               emask, cpu_if.busy, cpu_if.irq_valid);
    end
    pb = 1'b1; chan = 4'd0;
    cyc(2);
    checks++;
    if (cpu_if.irq_valid !== 1'b1 || cpu_if.irq_vector !== 5'd9) begin
      errors++;
      $display("FAIL rst_svc_idle got v=%0b vec=%0d exp 1/9", cpu_if.irq_valid, cpu_if.irq_vector);
    end
    finish_service();
  endtask

  task automatic enter_vec0_service();
    pa = 1'b1; chan = 4'd0;
    cyc(2);
    cpu_if.irq_ready = 1'b1;
    cyc(1);
    clear_inputs();
    checks++;
    if (cpu_if.busy !== 1'b1 || emask !== 27'd1) begin
      errors++;
      $display("FAIL to_entry got busy=%0b emask=%h exp 1/0000001", cpu_if.busy, emask);
    end
  endtask

  task automatic test_timeout();
`ifdef IRQ_TIMEOUT_EN
    enter_vec0_service();
    for (int i = 1; i < TO; i++) begin
      cyc(1);
      checks++;
      if (cpu_if.busy !== 1'b1 || cpu_if.timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL to_wait cycle=%0d got busy=%0b terr=%0b exp 1/0", i, cpu_if.busy, cpu_if.timeout_err);
      end
    end
    cyc(1);
    checks++;
    if (cpu_if.timeout_err !== 1'b1 || emask !== 27'd0 || cpu_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL to_expire got terr=%0b emask=%h busy=%0b exp 1/0/0",
               cpu_if.timeout_err, emask, cpu_if.busy);
    end
    cyc(1);
    checks++;
    if (cpu_if.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse_width got=%0b exp=0", cpu_if.timeout_err);
    end
    enter_vec0_service();
    cyc(TO - 1);
    cpu_if.eoi = 1'b1;
    cyc(1);
    cpu_if.eoi = 1'b0;
    checks++;
    if (cpu_if.timeout_err !== 1'b0 || cpu_if.busy !== 1'b0 || emask !== 27'd0) begin
      errors++;
      $display("FAIL to_eoi_wins got terr=%0b busy=%0b emask=%h exp 0/0/0",
               cpu_if.timeout_err, cpu_if.busy, emask);
    end
    cyc(1);
`else
    enter_vec0_service();
    for (int i = 0; i < 3 * TO; i++) begin
      cyc(1);
      checks++;
      if (cpu_if.busy !== 1'b1 || cpu_if.timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL no_wd_hold cycle=%0d got busy=%0b terr=%0b exp 1/0", i, cpu_if.busy, cpu_if.timeout_err);
      end
    end
    cpu_if.eoi = 1'b1;
    cyc(1);
    cpu_if.eoi = 1'b0;
    cyc(1);
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 30) begin
        pa   = ($urandom_range(0, 3) == 0);
        pb   = ($urandom_range(0, 2) == 0);
        pc   = ($urandom_range(0, 1) == 0);
        chan = 4'($urandom_range(0, 9));
      end
      cpu_if.irq_ready = ($urandom_range(0, 99) < 40);
      cpu_if.eoi       = ($urandom_range(0, 99) < 12);
      rst              = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0;
    clear_inputs();
    cyc(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_sticky();
    test_chan9();
    test_rst_service();
    test_timeout();
    test_random();
    sb_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
